// File: rtl/vga_pkg.sv
// Shared raster timing defaults and the frame-update handshake state type.
package vga_pkg;

   localparam int unsigned CNT_W     = 10;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } frame_state_t;

endpackage

// File: rtl/scan_counter.sv
// Modulo-N counter with enable; exposes the next value so callers can register decodes without skew.
module scan_counter
   import vga_pkg::*;
#(
   parameter int unsigned N = 800,
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next,
   output logic         wrap
);

   always_comb begin
      wrap       = en && (count == W'(N - 1));
      count_next = count;
      if (wrap)
         count_next = '0;
      else if (en)
         count_next = count + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster scan: pixel enable, DrawX/DrawY, syncs/blank and the per-frame update handshake.
module vga_scan_generator #(
   parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
   parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
   parameter int unsigned H_BACK    = vga_pkg::H_BACK,
   parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
   parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
   parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_ack,
   output logic       pixel_clk,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       sync,
   output logic       line_start,
   output logic       frame_start,
   output logic       frame_req,
   output logic [7:0] overrun_cnt
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_scan_generator: H_TOTAL/V_TOTAL must not exceed 1024");
   end

   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

   logic                  pix_en;
   logic [9:0]            x_next;
   logic [9:0]            y_next;
   logic                  x_wrap;
   logic                  y_wrap;
   vga_pkg::frame_state_t state;

   assign pix_en = pixel_clk;
   assign sync   = 1'b0;

   scan_counter #(.N(H_TOTAL), .W(10)) u_h_cnt (
      .clk        (Clk),
      .rst        (Reset),
      .en         (pix_en),
      .count      (DrawX),
      .count_next (x_next),
      .wrap       (x_wrap)
   );

   scan_counter #(.N(V_TOTAL), .W(10)) u_v_cnt (
      .clk        (Clk),
      .rst        (Reset),
      .en         (x_wrap),
      .count      (DrawY),
      .count_next (y_next),
      .wrap       (y_wrap)
   );

   // The vertical counter may only wrap at the frame corner, together with DrawX.
   assert property (@(posedge Clk) disable iff (Reset) y_wrap |-> x_wrap);

   // Decodes use the counters' next values so they change on the same edge as DrawX/DrawY.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pixel_clk   <= 1'b0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pixel_clk   <= ~pixel_clk;
         hs          <= !((x_next >= HS_START) && (x_next < HS_END));
         vs          <= !((y_next >= VS_START) && (y_next < VS_END));
         blank       <= (x_next < H_VIS) && (y_next < V_VIS);
         line_start  <= x_wrap;
         frame_start <= x_wrap && (y_next == V_VIS);
      end
   end

   // In REQ, a coincident ack retires the old frame while the new frame_start re-arms the request.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= vga_pkg::IDLE;
         frame_req   <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         case (state)
            vga_pkg::IDLE: begin
               if (frame_start) begin
                  state     <= vga_pkg::REQ;
                  frame_req <= 1'b1;
               end
            end
            vga_pkg::REQ: begin
               if (frame_start) begin
                  if (!frame_ack && (overrun_cnt != '1))
                     overrun_cnt <= overrun_cnt + 8'd1;
               end else if (frame_ack) begin
                  state     <= vga_pkg::IDLE;
                  frame_req <= 1'b0;
               end
            end
            default: begin
               state     <= vga_pkg::IDLE;
               frame_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: shrunk-timing instance with scoreboard plus a default-timing instance.
module tb_vga_scan_generator;

   localparam int unsigned HV  = 4;
   localparam int unsigned HF  = 1;
   localparam int unsigned HSW = 2;
   localparam int unsigned HB  = 1;
   localparam int unsigned VV  = 4;
   localparam int unsigned VF  = 1;
   localparam int unsigned VSW = 1;
   localparam int unsigned VB  = 1;
   localparam int unsigned HT  = HV + HF + HSW + HB;
   localparam int unsigned VT  = VV + VF + VSW + VB;
   localparam int unsigned FRAME_CLK = 2 * HT * VT;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       pclk;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       ls;
      logic       fs;
      logic       req;
      logic [7:0] ovr;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic frame_ack = 1'b0;
   logic d_ack = 1'b0;

   logic       s_pclk, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_req;
   logic [9:0] s_x, s_y;
   logic [7:0] s_ovr;
   logic       d_pclk, d_hs, d_vs, d_blank, d_sync, d_ls, d_fs, d_req;
   logic [9:0] d_x, d_y;
   logic [7:0] d_ovr;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned sb_fail = 0;

   exp_t q[$];

   always #5 Clk = ~Clk;

   vga_scan_generator #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_ack(frame_ack), .pixel_clk(s_pclk),
      .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync),
      .line_start(s_ls), .frame_start(s_fs), .frame_req(s_req), .overrun_cnt(s_ovr)
   );

   vga_scan_generator dut_def (
      .Clk(Clk), .Reset(Reset), .frame_ack(d_ack), .pixel_clk(d_pclk),
      .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank), .sync(d_sync),
      .line_start(d_ls), .frame_start(d_fs), .frame_req(d_req), .overrun_cnt(d_ovr)
   );

   // Reference: position follows from edges since reset release (one pixel per two Clk).
   int unsigned k = 0;
   int unsigned m_ovr = 0;
   logic m_req = 1'b0;
   logic m_fs = 1'b0;

   always @(posedge Clk) begin
      exp_t e;
      int unsigned pos, x, y;
      logic adv;
      if (Reset) begin
         k = 0; m_req = 1'b0; m_fs = 1'b0; m_ovr = 0;
      end else begin
         if (m_req) begin
            if (m_fs) begin
               if (!frame_ack && m_ovr < 255) m_ovr++;
            end else if (frame_ack) begin
               m_req = 1'b0;
            end
         end else if (m_fs) begin
            m_req = 1'b1;
         end
         k++;
         pos = (k / 2) % (HT * VT);
         x = pos % HT;
         y = pos / HT;
         adv = (k % 2 == 0);
         m_fs = adv && x == 0 && y == VV;
         e.x = 10'(x);
         e.y = 10'(y);
         e.pclk = (k % 2 == 1);
         e.hs = !(x >= HV + HF && x < HV + HF + HSW);
         e.vs = !(y >= VV + VF && y < VV + VF + VSW);
         e.blank = (x < HV) && (y < VV);
         e.ls = adv && x == 0;
         e.fs = m_fs;
         e.req = m_req;
         e.ovr = 8'(m_ovr);
         q.push_back(e);
      end
   end

   always @(negedge Clk) begin
      exp_t e;
      if (Reset) begin
         q.delete();
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (sb_fail < 20) begin
            n_tests++;
            if ({s_x, s_y, s_pclk, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_req, s_ovr} !==
                {e.x, e.y, e.pclk, e.hs, e.vs, e.blank, 1'b0, e.ls, e.fs, e.req, e.ovr}) begin
               n_fail++;
               sb_fail++;
               $display("FAIL scoreboard t=%0t got x=%0d y=%0d pclk=%b hs=%b vs=%b blank=%b sync=%b ls=%b fs=%b req=%b ovr=%0d expected x=%0d y=%0d pclk=%b hs=%b vs=%b blank=%b sync=0 ls=%b fs=%b req=%b ovr=%0d",
                        $time, s_x, s_y, s_pclk, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_req, s_ovr,
                        e.x, e.y, e.pclk, e.hs, e.vs, e.blank, e.ls, e.fs, e.req, e.ovr);
            end
         end
      end
   end

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      n_tests++;
      if ({s_x, s_y} !== 20'd0) begin
         n_fail++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", s_x, s_y);
      end
      n_tests++;
      if ({s_hs, s_vs, d_hs, d_vs} !== 4'b1111) begin
         n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b dhs=%b dvs=%b expected all 1", s_hs, s_vs, d_hs, d_vs);
      end
      n_tests++;
      if ({s_pclk, s_blank, s_sync, s_ls, s_fs, s_req, s_ovr} !== 14'd0) begin
         n_fail++; $display("FAIL reset_misc: got pclk=%b blank=%b sync=%b ls=%b fs=%b req=%b ovr=%0d expected 0",
                            s_pclk, s_blank, s_sync, s_ls, s_fs, s_req, s_ovr);
      end
   endtask

   task automatic test_default_timing();
      int unsigned c;
      int unsigned hs_low;
      bit seen;
      Reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge Clk);
         if (d_x == 10'd639) begin seen = 1'b1; break; end
      end
      n_tests++;
      if (!seen || d_blank !== 1'b1) begin
         n_fail++; $display("FAIL dflt_blank_639: seen=%0d got blank=%b expected 1", seen, d_blank);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (d_x == 10'd640) begin seen = 1'b1; break; end
      end
      n_tests++;
      if (!seen || d_blank !== 1'b0) begin
         n_fail++; $display("FAIL dflt_blank_640: seen=%0d got blank=%b expected 0", seen, d_blank);
      end
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge Clk);
         if (d_ls === 1'b1) begin seen = 1'b1; break; end
      end
      c = 0;
      hs_low = 0;
      do begin
         if (d_hs === 1'b0) hs_low++;
         @(negedge Clk);
         c++;
      end while (d_ls !== 1'b1 && c < 4000);
      n_tests++;
      if (!seen || c != 1600) begin
         n_fail++; $display("FAIL dflt_line_period: got %0d Clk expected 1600", c);
      end
      n_tests++;
      if (hs_low != 192) begin
         n_fail++; $display("FAIL dflt_hs_width: got %0d Clk expected 192", hs_low);
      end
   endtask

   task automatic test_frame_boundary();
      int unsigned c;
      logic blank_in, blank_out;
      bit seen_in, seen_out, seen_fs;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      seen_in = 0; seen_out = 0; seen_fs = 0;
      blank_in = 1'bx; blank_out = 1'bx;
      c = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge Clk);
         c++;
         if (s_x == 10'(HV - 1) && s_y == 10'(VV - 1)) begin seen_in = 1; blank_in = s_blank; end
         if (s_x == 10'(HV) && s_y == 10'(VV - 1) && !seen_out) begin seen_out = 1; blank_out = s_blank; end
         if (s_fs === 1'b1) begin seen_fs = 1; break; end
      end
      n_tests++;
      if (!seen_in || blank_in !== 1'b1) begin
         n_fail++; $display("FAIL blank_last_visible: got %b expected 1", blank_in);
      end
      n_tests++;
      if (!seen_out || blank_out !== 1'b0) begin
         n_fail++; $display("FAIL blank_first_hidden: got %b expected 0", blank_out);
      end
      n_tests++;
      if (!seen_fs || c != 2 * HT * VV || s_x !== 10'd0 || s_y !== 10'(VV)) begin
         n_fail++; $display("FAIL first_frame_start: got Clk=%0d at %0d,%0d expected Clk=%0d at 0,%0d",
                            c, s_x, s_y, 2 * HT * VV, VV);
      end
      @(negedge Clk);
      n_tests++;
      if (s_fs !== 1'b0 || s_req !== 1'b1) begin
         n_fail++; $display("FAIL req_rise: got fs=%b req=%b expected fs=0 req=1", s_fs, s_req);
      end
   endtask

   task automatic test_ack();
      repeat (99) @(negedge Clk);
      n_tests++;
      if (s_req !== 1'b1) begin
         n_fail++; $display("FAIL req_hold: got %b expected 1", s_req);
      end
      frame_ack = 1'b1;
      @(negedge Clk);
      frame_ack = 1'b0;
      n_tests++;
      if (s_req !== 1'b0 || s_ovr !== 8'd0) begin
         n_fail++; $display("FAIL ack_release: got req=%b ovr=%0d expected req=0 ovr=0", s_req, s_ovr);
      end
   endtask

   task automatic test_overrun();
      int unsigned c, n, vs_low, hs_low;
      int unsigned t_fs[3];
      c = 0; n = 0; vs_low = 0; hs_low = 0;
      t_fs = '{0, 0, 0};
      while (n < 3 && c < 4 * FRAME_CLK) begin
         @(negedge Clk);
         c++;
         if (n == 1) begin
            if (s_vs === 1'b0) vs_low++;
            if (s_hs === 1'b0) hs_low++;
         end
         if (s_fs === 1'b1) begin t_fs[n] = c; n++; end
      end
      n_tests++;
      if (n != 3 || t_fs[1] - t_fs[0] != FRAME_CLK) begin
         n_fail++; $display("FAIL frame_period: got n=%0d period=%0d expected n=3 period=%0d", n, t_fs[1] - t_fs[0], FRAME_CLK);
      end
      n_tests++;
      if (vs_low != 2 * VSW * HT) begin
         n_fail++; $display("FAIL vs_width: got %0d Clk expected %0d", vs_low, 2 * VSW * HT);
      end
      n_tests++;
      if (hs_low != 2 * HSW * VT) begin
         n_fail++; $display("FAIL hs_width_frame: got %0d Clk expected %0d", hs_low, 2 * HSW * VT);
      end
      @(negedge Clk);
      n_tests++;
      if (s_req !== 1'b1 || s_ovr !== 8'd2) begin
         n_fail++; $display("FAIL overrun_two: got req=%b ovr=%0d expected req=1 ovr=2", s_req, s_ovr);
      end
   endtask

   task automatic test_same_cycle_ack();
      bit seen;
      seen = 0;
      for (int i = 0; i < FRAME_CLK + 10; i++) begin
         @(negedge Clk);
         if (s_fs === 1'b1) begin seen = 1; break; end
      end
      frame_ack = 1'b1;
      @(negedge Clk);
      frame_ack = 1'b0;
      n_tests++;
      if (!seen || s_req !== 1'b1 || s_ovr !== 8'd2) begin
         n_fail++; $display("FAIL same_cycle_ack: seen=%0d got req=%b ovr=%0d expected req=1 ovr=2", seen, s_req, s_ovr);
      end
   endtask

   task automatic test_saturation();
      repeat (300 * FRAME_CLK) @(negedge Clk);
      n_tests++;
      if (s_req !== 1'b1 || s_ovr !== 8'd255) begin
         n_fail++; $display("FAIL overrun_saturate: got req=%b ovr=%0d expected req=1 ovr=255", s_req, s_ovr);
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      int unsigned fs_cnt, first_ls;
      seen = 0;
      for (int i = 0; i < FRAME_CLK + 10; i++) begin
         @(negedge Clk);
         if (s_x == 10'd6 && s_y == 10'd2) begin seen = 1; break; end
      end
      #2 Reset = 1'b1;
      #1;
      n_tests++;
      if (!seen || {s_x, s_y} !== 20'd0 || {s_hs, s_vs} !== 2'b11 ||
          {s_pclk, s_blank, s_ls, s_fs, s_req, s_ovr} !== 13'd0) begin
         n_fail++; $display("FAIL async_reset: seen=%0d got x=%0d y=%0d hs=%b vs=%b pclk=%b blank=%b req=%b ovr=%0d expected reset values",
                            seen, s_x, s_y, s_hs, s_vs, s_pclk, s_blank, s_req, s_ovr);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      fs_cnt = 0;
      first_ls = 0;
      for (int c = 1; c < 2 * HT * VV; c++) begin
         @(negedge Clk);
         if (s_fs === 1'b1) fs_cnt++;
         if (s_ls === 1'b1 && first_ls == 0) first_ls = c;
      end
      n_tests++;
      if (fs_cnt != 0 || first_ls != 2 * HT) begin
         n_fail++; $display("FAIL restart_pulses: got fs=%0d first_ls=%0d expected fs=0 first_ls=%0d", fs_cnt, first_ls, 2 * HT);
      end
      @(negedge Clk);
      n_tests++;
      if (s_fs !== 1'b1) begin
         n_fail++; $display("FAIL restart_frame_start: got %b expected 1", s_fs);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_default_timing();
      test_frame_boundary();
      test_ack();
      test_overrun();
      test_same_cycle_ack();
      test_saturation();
      test_mid_reset();
      repeat (FRAME_CLK) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
